jts16_busctl: RTL and testbench

Parametrised 68000 bus controller for the System 16 CPU subsystems. It decodes the address into `NCS` chip-select regions and generates DTACKn, with per-region wait-for-ready. It also raises BERRn for unmapped accesses and runs a 7-level prioritised interrupt controller with autovector acknowledge. It sits between `jtframe_m68k` and the memory/peripheral blocks, replacing ad-hoc decode/DTACK/IRQ logic in each game's main module.

---
 rtl/jts16_busctl.sv | 106 ++++++++++
 tb/tb_jts16_busctl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jts16_busctl.sv
// jts16_busctl: 68000 chip-select decode, DTACK/BERR/VPA generation and autovector IRQ controller.
// Optional wait-state timeout enabled by defining JTS16_BUSCTL_TIMEOUT_EN.
module jts16_busctl #(
  parameter int              NCS      = 8,
  parameter logic [NCS*8-1:0] CS_MATCH = '0,
  parameter logic [NCS*8-1:0] CS_MASK  = '0,
  parameter logic [NCS-1:0]   CS_WAIT  = '0,
  parameter int              TOUT     = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_cen,
  input  logic           cpu_cenb,
  input  logic [23:1]    A,
  input  logic           ASn,
  input  logic [2:0]     FC,
  output logic [NCS-1:0] cs,
  input  logic [NCS-1:0] ok,
  output logic           DTACKn,
  output logic           BERRn,
  output logic           VPAn,
  input  logic [6:0]     irq_src,
  output logic [2:0]     IPLn
);
  typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, ERR, IACK} state_t;
  state_t state_q, state_d;
  logic [NCS-1:0] cs_q, cs_d, dec;
  logic dtackn_q, dtackn_d, berrn_q, berrn_d, vpan_q, vpan_d;
  logic [6:0] pend_q, pend_d, hist_q, clr;
  logic [7:0] lvl;
  logic [2:0] ipln_q, ipln_d;
  logic hit, wt, rdy, tout, iack_go, unused_a;
  always_comb begin
    dec = '0;
    for (int i = NCS-1; i >= 0; i--)
      if ((A[23:16] & CS_MASK[i*8+:8]) == CS_MATCH[i*8+:8]) begin
        dec = '0;
        dec[i] = 1'b1;
      end
  end
  always_comb hit = |cs_q;
  always_comb wt = |(cs_q & CS_WAIT);
  always_comb rdy = |(cs_q & ok);
  always_comb unused_a = ^{A[15:4], cpu_cen, 32'(TOUT)};
`ifdef JTS16_BUSCTL_TIMEOUT_EN
  localparam int CW = $clog2(TOUT+1) > 8 ? $clog2(TOUT+1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = state_q != WAIT ? '0 : cnt_q + CW'(cpu_cen);
  always_comb tout = state_q == WAIT && cnt_q == CW'(TOUT);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  always_comb tout = 1'b0;
`endif
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    if (ASn) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = FC == 3'd7 ? IACK : DECODE;
        DECODE:  state_d = !hit ? ERR : wt ? WAIT : ACK;
        WAIT:    state_d = rdy ? ACK : tout ? ERR : WAIT;
        default: state_d = state_q;
      endcase
  end
  // Strobes may fall straight from DECODE so the fastest access needs no extra clock.
  always_comb begin
    cs_d     = ASn ? '0 : state_q == IDLE ? (FC == 3'd7 ? '0 : dec) : cs_q;
    dtackn_d = ASn | (dtackn_q & ~(cpu_cenb & (state_q == ACK || (state_q == DECODE && hit && !wt))));
    berrn_d  = ASn | (berrn_q & ~(cpu_cenb & (state_q == ERR || (state_q == DECODE && !hit))));
    vpan_d   = ASn | (vpan_q & ~(cpu_cenb & state_q == IACK));
  end
  always_comb begin
    iack_go = state_q == IDLE && !ASn && FC == 3'd7;
    lvl     = 8'd1 << A[3:1];
    clr     = iack_go ? lvl[7:1] : '0;
    pend_d  = (pend_q & ~clr) | (irq_src & ~hist_q);
    ipln_d  = 3'b111;
    for (int k = 0; k < 7; k++)
      if (pend_q[k]) ipln_d = ~3'(k+1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q     <= '0;
      dtackn_q <= 1'b1;
      berrn_q  <= 1'b1;
      vpan_q   <= 1'b1;
      pend_q   <= '0;
      hist_q   <= '0;
      ipln_q   <= 3'b111;
    end else begin
      cs_q     <= cs_d;
      dtackn_q <= dtackn_d;
      berrn_q  <= berrn_d;
      vpan_q   <= vpan_d;
      pend_q   <= pend_d;
      hist_q   <= irq_src;
      ipln_q   <= ipln_d;
    end
  end
  assign cs     = cs_q;
  assign DTACKn = dtackn_q;
  assign BERRn  = berrn_q;
  assign VPAn   = vpan_q;
  assign IPLn   = ipln_q;
endmodule

// File: tb/tb_jts16_busctl.sv
// tb_jts16_busctl: randomized directed bench for jts16_busctl with a region/IRQ reference model.
module tb_jts16_busctl;
  localparam int NCS = 4, TOUT = 16;
  logic clk = 0, rst = 1, cpu_cen = 0, cpu_cenb = 0, asn = 1;
  logic [23:1] a = '0;
  logic [2:0] fc = '0;
  logic [NCS-1:0] cs, ok = '0;
  logic dtackn, berrn, vpan;
  logic [6:0] irq_src = '0;
  logic [2:0] ipln;
  logic last_cen = 0, last_cenb = 0;
  int ph = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_match [4] = '{8'h00, 8'h40, 8'h80, 8'hC0};
  logic [7:0] m_mask  [4] = '{8'hC0, 8'hC0, 8'hC0, 8'hFF};
  bit         m_wait  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [6:0] m_pend = '0;
  int cur_r;
  logic [NCS-1:0] exp_cs;

  jts16_busctl #(
    .NCS(NCS), .CS_MATCH(32'hC0_80_40_00), .CS_MASK(32'hFF_C0_C0_C0),
    .CS_WAIT(4'b1010), .TOUT(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .cpu_cenb(cpu_cenb), .A(a), .ASn(asn),
    .FC(fc), .cs(cs), .ok(ok), .DTACKn(dtackn), .BERRn(berrn), .VPAn(vpan),
    .irq_src(irq_src), .IPLn(ipln)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    ph = (ph + 1) % 4;
    cpu_cen = ph == 0;
    cpu_cenb = ph == 2;
  end
  always @(posedge clk) begin
    last_cen <= cpu_cen;
    last_cenb <= cpu_cenb;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int region(input logic [23:0] addr);
    for (int i = 0; i < 4; i++)
      if ((addr[23:16] & m_mask[i]) == m_match[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_ipl(input logic [6:0] p);
    int top = 0;
    for (int k = 0; k < 7; k++) if (p[k]) top = k + 1;
    return 3'(7 - top);
  endfunction

  task automatic start(input logic [23:0] addr);
    tick();
    a = addr[23:1];
    fc = 3'($urandom_range(0, 6));
    asn = 0;
    cur_r = region(addr);
    exp_cs = cur_r < 0 ? '0 : 4'(1 << cur_r);
    tick();
    check("cs_at_1clk", 32'(cs), 32'(exp_cs));
    check("dtack_early", 32'(dtackn), 1);
    check("berr_early", 32'(berrn), 1);
  endtask

  task automatic wait_ok(input int n);
    repeat (n) begin
      tick();
      check("wait_dtack", 32'(dtackn), 1);
      check("wait_berr", 32'(berrn), 1);
      check("wait_cs", 32'(cs), 32'(exp_cs));
    end
    ok[cur_r] = 1'b1;
    tick();
    ok = '0;
    check("pulse_dtack", 32'(dtackn), 1);
  endtask

  task automatic strobe();
    logic fallen = 0;
    repeat (6) begin
      tick();
      fallen |= last_cenb;
      if (cur_r < 0) begin
        check("berr_cenb", 32'(berrn), 32'(!fallen));
        check("err_dtack", 32'(dtackn), 1);
      end else begin
        check("dtack_cenb", 32'(dtackn), 32'(!fallen));
        check("ack_berr", 32'(berrn), 1);
      end
      check("hold_cs", 32'(cs), 32'(exp_cs));
      check("bus_vpa", 32'(vpan), 1);
    end
  endtask

  task automatic release_bus();
    asn = 1;
    tick();
    check("rel_cs", 32'(cs), 0);
    check("rel_dtack", 32'(dtackn), 1);
    check("rel_berr", 32'(berrn), 1);
    check("rel_vpa", 32'(vpan), 1);
  endtask

  task automatic access(input logic [23:0] addr, input int okdly);
    start(addr);
    if (cur_r >= 0 && m_wait[cur_r]) wait_ok(okdly);
    strobe();
    release_bus();
  endtask

  task automatic irq_pulse(input int k);
    logic [2:0] old = exp_ipl(m_pend);
    tick();
    irq_src[k] = 1'b1;
    m_pend[k] = 1'b1;
    tick();
    check("ipl_1clk", 32'(ipln), 32'(old));
    irq_src[k] = 1'b0;
    tick();
    check("ipl_2clk", 32'(ipln), 32'(exp_ipl(m_pend)));
  endtask

  task automatic iack(input int l, input bit also_edge);
    logic [2:0] old = exp_ipl(m_pend);
    logic fallen = 0;
    tick();
    a = 23'($urandom);
    a[3:1] = 3'(l);
    fc = 3'd7;
    asn = 0;
    if (also_edge) irq_src[l-1] = 1'b1;
    m_pend[l-1] = also_edge;
    tick();
    check("iack_cs", 32'(cs), 0);
    check("iack_vpa_early", 32'(vpan), 1);
    check("iack_ipl_old", 32'(ipln), 32'(old));
    repeat (6) begin
      tick();
      fallen |= last_cenb;
      check("iack_vpa", 32'(vpan), 32'(!fallen));
      check("iack_ipl", 32'(ipln), 32'(exp_ipl(m_pend)));
      check("iack_dtack", 32'(dtackn), 1);
      check("iack_hold_cs", 32'(cs), 0);
    end
    irq_src = '0;
    release_bus();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_cs", 32'(cs), 0);
    check("rst_dtack", 32'(dtackn), 1);
    check("rst_berr", 32'(berrn), 1);
    check("rst_vpa", 32'(vpan), 1);
    check("rst_ipl", 32'(ipln), 7);
    rst = 0;
    access(24'h012345, 1);
    access(24'h412345, 20);
    access(24'hFF0000, 1);
    irq_pulse(3);
    irq_pulse(5);
    iack(6, 0);
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: access(24'($urandom), int'($urandom_range(1, 8)));
        1: irq_pulse(int'($urandom_range(0, 6)));
        default: iack(int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
      endcase
    end
    iack(2, 1);
    iack(7, 1);
    irq_pulse(4);
    start(24'h401234);
    repeat (3) begin
      tick();
      check("pre_rst_dtack", 32'(dtackn), 1);
    end
    rst = 1;
    tick();
    m_pend = '0;
    check("midrst_cs", 32'(cs), 0);
    check("midrst_dtack", 32'(dtackn), 1);
    check("midrst_berr", 32'(berrn), 1);
    check("midrst_ipl", 32'(ipln), 7);
    rst = 0;
    tick();
    check("rst_restart_cs", 32'(cs), 32'(exp_cs));
    wait_ok(2);
    strobe();
    release_bus();
    start(24'hC05555);
`ifdef JTS16_BUSCTL_TIMEOUT_EN
    begin
      int n = 0, t = 0;
      while (berrn === 1'b1 && t < 300) begin
        tick();
        t++;
        n += int'(last_cen);
      end
      check("tout_berr", 32'(berrn), 0);
      check("tout_on_cenb", 32'(last_cenb), 1);
      check("tout_cs", 32'(cs), 32'(exp_cs));
      check("tout_cnt", 32'(n >= TOUT && n <= TOUT + 1), 1);
      check("tout_dtack", 32'(dtackn), 1);
      release_bus();
    end
`else
    repeat (1000) tick();
    check("no_tout_berr", 32'(berrn), 1);
    check("no_tout_dtack", 32'(dtackn), 1);
    check("no_tout_cs", 32'(cs), 32'(exp_cs));
    wait_ok(1);
    strobe();
    release_bus();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
